vtg_deserializer: RTL and testbench

Serial-to-parallel front end that feeds the team's parameterised load register.
- Collects a framed serial bit stream into a SIZE-bit word.
- On the word's final bit, presents the word on dataout with a one-cycle we pulse, so it can connect directly to a register's datain/we.
- Flags broken frames on frame_err.

---
 rtl/vtg_pkg.sv | 16 +
 rtl/vtg_deserializer.sv | 94 +++++++++
 tb/tb_vtg_deserializer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/vtg_pkg.sv
// Shared definitions for the vtg serial front end: FSM state codes and the
// counter-sizing helper.
package vtg_pkg;

  localparam logic VTG_DES_IDLE  = 1'b0;
  localparam logic VTG_DES_SHIFT = 1'b1;

  // Bits needed to hold values 0..n-1 (minimum 1).
  function automatic int vtg_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/vtg_deserializer.sv
// Framed serial-to-parallel converter; emits each completed word with a
// one-cycle we pulse and pulses frame_err when a partial word is dropped.
module vtg_deserializer
  import vtg_pkg::*;
#(
  parameter int              SIZE      = 8,
  parameter bit              MSB_FIRST = 1'b1,
  parameter logic [SIZE-1:0] RST_VAL   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sin,
  input  logic            sin_valid,
  input  logic            sof,
  output logic [SIZE-1:0] dataout,
  output logic            we,
  output logic            busy,
  output logic            frame_err
);

  localparam int CW = vtg_clog2(SIZE + 1);

  logic            state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] sh_q, sh_d;
  logic [SIZE-1:0] dout_q, dout_d;
  logic            we_q, we_d;
  logic            err_q, err_d;

  logic [SIZE-1:0] sh_next;   // shift register with sin appended
  logic [SIZE-1:0] sh_first;  // fresh word holding only sin as its first bit

  always_comb begin
    if (MSB_FIRST) begin
      sh_next  = {sh_q[SIZE-2:0], sin};
      sh_first = {{(SIZE-1){1'b0}}, sin};
    end else begin
      sh_next  = {sin, sh_q[SIZE-1:1]};
      sh_first = {sin, {(SIZE-1){1'b0}}};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    if (sin_valid) begin
      if (sof) begin
        // A start in the middle of a word throws the partial word away.
        err_d   = (state_q == VTG_DES_SHIFT);
        sh_d    = sh_first;
        cnt_d   = CW'(1);
        state_d = VTG_DES_SHIFT;
      end else if (state_q == VTG_DES_SHIFT) begin
        sh_d = sh_next;
        if (cnt_q == CW'(SIZE - 1)) begin
          dout_d  = sh_next;
          we_d    = 1'b1;
          cnt_d   = '0;
          state_d = VTG_DES_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= VTG_DES_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= RST_VAL;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign dataout   = dout_q;
  assign we        = we_q;
  assign busy      = (state_q == VTG_DES_SHIFT);
  assign frame_err = err_q;

endmodule

// File: tb/tb_vtg_deserializer.sv
// Drives one stimulus stream into an MSB-first and an LSB-first instance and
// scores both against a bit-list reference model.
module tb_vtg_deserializer;

  localparam int SIZE = 8;
  localparam logic [SIZE-1:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sin = 1'b0, sin_valid = 1'b0, sof = 1'b0;
  logic [SIZE-1:0] dout_m, dout_l;
  logic we_m, we_l, busy_m, busy_l, err_m, err_l;

  always #5 clk = ~clk;

  vtg_deserializer #(.SIZE(SIZE), .MSB_FIRST(1'b1), .RST_VAL(RV)) dut_m (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .dataout(dout_m), .we(we_m), .busy(busy_m), .frame_err(err_m));

  vtg_deserializer #(.SIZE(SIZE), .MSB_FIRST(1'b0), .RST_VAL(RV)) dut_l (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .dataout(dout_l), .we(we_l), .busy(busy_l), .frame_err(err_l));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the current frame is a list of received bits.
  bit              bits[$];
  bit              in_frame;
  bit              exp_we, exp_err;
  logic [SIZE-1:0] last_m, last_l;
  logic [SIZE-1:0] q_m[$], q_l[$];

  task automatic model_reset();
    bits.delete();
    in_frame = 0; exp_we = 0; exp_err = 0;
    last_m = RV; last_l = RV;
    q_m.delete(); q_l.delete();
  endtask

  task automatic model_step(input bit v, input bit s, input bit f);
    logic [SIZE-1:0] wm, wl;
    exp_we = 0; exp_err = 0;
    if (!v) return;
    if (f) begin
      exp_err = in_frame;
      bits.delete(); bits.push_back(s); in_frame = 1;
    end else if (in_frame) begin
      bits.push_back(s);
      if (bits.size() == SIZE) begin
        wm = '0; wl = '0;
        for (int i = 0; i < SIZE; i++) begin
          wm = wm | (SIZE'(bits[i]) << (SIZE - 1 - i));
          wl = wl | (SIZE'(bits[i]) << i);
        end
        last_m = wm; last_l = wl;
        q_m.push_back(wm); q_l.push_back(wl);
        exp_we = 1; in_frame = 0; bits.delete();
      end
    end
  endtask

  task automatic step(input bit v, input bit s, input bit f);
    sin_valid = v; sin = s; sof = f;
    @(posedge clk);
    model_step(v, s, f);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic do_reset();
    sin_valid = 0; sof = 0; sin = 0;
    rst = 0;
    model_reset();
    @(posedge clk);
    #2 rst = 1;
  endtask

  // Sends a word first-bit-first with sof on the first bit, plus optional gaps.
  task automatic send_word(input logic [SIZE-1:0] seq, input int max_gap);
    for (int i = 0; i < SIZE; i++) begin
      step(1, seq[SIZE-1-i], i == 0);
      if (max_gap > 0 && i < SIZE - 1) idle($urandom_range(0, max_gap));
    end
  endtask

  always @(negedge clk) begin
    chk("we_m", we_m, exp_we);
    chk("we_l", we_l, exp_we);
    chk("err_m", err_m, exp_err);
    chk("err_l", err_l, exp_err);
    chk("busy_m", busy_m, in_frame);
    chk("busy_l", busy_l, in_frame);
    chk("hold_m", dout_m, last_m);
    chk("hold_l", dout_l, last_l);
    if (we_m) begin
      if (q_m.size() == 0) chk("word_m_unexpected", 1, 0);
      else chk("word_m", dout_m, q_m.pop_front());
    end
    if (we_l) begin
      if (q_l.size() == 0) chk("word_l_unexpected", 1, 0);
      else chk("word_l", dout_l, q_l.pop_front());
    end
  end

  int we_cnt, err_cnt, t1, t2;
  always @(posedge clk) begin
    if (we_m) we_cnt++;
    if (err_m) err_cnt++;
  end

  initial begin
    model_reset();
    #12 rst = 1;
    idle(2);
    do_reset();
    chk("rst_dout", dout_m, 8'hA5);
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    idle(1);
    chk("idle_drop_dout", dout_m, 8'hA5);
    chk("idle_drop_busy", busy_m, 0);

    we_cnt = 0;
    send_word(8'b1011_0010, 0);
    idle(1);
    chk("msb_b2", dout_m, 8'hB2);
    chk("lsb_4d", dout_l, 8'h4D);
    chk("we_once", we_cnt, 1);

    we_cnt = 0;
    send_word(8'b1011_0010, 5);
    idle(2);
    chk("gap_lsb_4d", dout_l, 8'h4D);
    chk("gap_we_once", we_cnt, 1);

    we_cnt = 0; err_cnt = 0;
    step(1, 1, 1); step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    send_word(8'h3C, 0);
    idle(1);
    chk("resync_err_once", err_cnt, 1);
    chk("resync_3c", dout_m, 8'h3C);
    chk("resync_we_once", we_cnt, 1);

    we_cnt = 0; err_cnt = 0;
    send_word(8'hFF, 0);
    t1 = $time;
    send_word(8'h01, 0);
    t2 = $time;
    idle(1);
    chk("b2b_spacing", (t2 - t1) / 10, 8);
    chk("b2b_we", we_cnt, 2);
    chk("b2b_no_err", err_cnt, 0);
    chk("b2b_01", dout_m, 8'h01);

    we_cnt = 0;
    send_word(8'h81, 0);
    step(1, 1, 1); step(1, 1, 0); step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    do_reset();
    send_word(8'h81, 0);
    idle(1);
    chk("rst_mid_81", dout_m, 8'h81);
    chk("rst_mid_lsb", dout_l, 8'h81);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 11) == 0);
    end
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
